count_checker: RTL and testbench

- Sequence checker sitting on the consuming end of a free-running up-counter bus such as the 4-bit counter.
- Samples the count value each enabled cycle, locks onto the sequence, then verifies every sample is previous+1 modulo 2^WIDTH.
- Flags mismatches, counts errors and wrap events; used as an in-design monitor and self-check for counter-driven logic.

---
 rtl/count_checker.sv | 147 ++++++++++++++
 tb/tb_count_checker.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
`default_nettype none
// ============================================================================
// Module   : count_checker
// Brief    : Free-running up-counter sequence monitor. Locks onto the observed
//            count, then flags any sample that is not previous+1 mod 2^WIDTH.
//            Optional macro COUNT_CHECKER_RST_TOL_EN: in LOCKED, an unexpected
//            sample of 0 is accepted as an upstream counter reset.
// Revision : 1.0 - initial release
// ============================================================================
module count_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       c_lock_cnt = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] c_err_max  = {ERR_W{1'b1}};
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

    state_t           r_state;
    logic [3:0]       r_match_cnt;
    logic [WIDTH-1:0] r_expected;
    logic             r_err_pulse;
    logic             r_wrap_pulse;
    logic [ERR_W-1:0] r_err_count;

    state_t           w_state_nxt;
    logic [3:0]       w_match_nxt;
    logic [WIDTH-1:0] w_expected_nxt;
    logic             w_err_pulse_nxt;
    logic             w_wrap_pulse_nxt;
    logic [ERR_W-1:0] w_err_count_nxt;

    logic [WIDTH-1:0] w_incr;
    logic             w_hit;
    logic [3:0]       w_match_inc;
    logic             w_upstream_rst;

    // Increment wraps naturally at WIDTH bits; no carry-out is kept.
    assign w_incr      = count_in + c_one;
    assign w_hit       = (count_in == r_expected);
    assign w_match_inc = r_match_cnt + 4'd1;

`ifdef COUNT_CHECKER_RST_TOL_EN
    assign w_upstream_rst = (count_in == '0);
`else
    assign w_upstream_rst = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_match_nxt      = r_match_cnt;
        w_expected_nxt   = r_expected;
        w_err_pulse_nxt  = 1'b0;
        w_wrap_pulse_nxt = 1'b0;
        w_err_count_nxt  = r_err_count;

        if (en) begin
            case (r_state)
                S_IDLE: begin
                    w_expected_nxt = w_incr;
                    w_match_nxt    = 4'd0;
                    w_state_nxt    = S_SYNC;
                end

                S_SYNC: begin
                    // Re-reference on every sample so only consecutive hits count.
                    w_expected_nxt = w_incr;
                    if (w_hit) begin
                        if (w_match_inc >= c_lock_cnt) begin
                            w_match_nxt = 4'd0;
                            w_state_nxt = S_LOCKED;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end else begin
                        w_match_nxt = 4'd0;
                    end
                end

                S_LOCKED: begin
                    if (w_hit) begin
                        w_expected_nxt   = w_incr;
                        w_wrap_pulse_nxt = (count_in == '0);
                    end else if (w_upstream_rst) begin
                        w_expected_nxt = c_one;
                    end else begin
                        w_err_pulse_nxt = 1'b1;
                        if (r_err_count != c_err_max) begin
                            w_err_count_nxt = r_err_count + ERR_W'(1);
                        end
                        w_expected_nxt = w_incr;
                        w_match_nxt    = 4'd0;
                        w_state_nxt    = S_SYNC;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_match_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_match_cnt  <= 4'd0;
            r_expected   <= '0;
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_match_cnt  <= w_match_nxt;
            r_expected   <= w_expected_nxt;
            r_err_pulse  <= w_err_pulse_nxt;
            r_wrap_pulse <= w_wrap_pulse_nxt;
            r_err_count  <= w_err_count_nxt;
        end
    end

    assign locked     = (r_state == S_LOCKED);
    assign expected   = r_expected;
    assign err_pulse  = r_err_pulse;
    assign wrap_pulse = r_wrap_pulse;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_count_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_checker
// Brief    : Randomized self-checking bench for count_checker (two instances,
//            ERR_W=8 and ERR_W=2) against a behavioural sequence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_checker;

    localparam int W    = 4;
    localparam int LOCK = 2;
    localparam int MODN = 1 << W;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] count_in;

    logic         locked_a, err_a, wrap_a;
    logic [W-1:0] exp_a;
    logic [7:0]   errc_a;
    logic         locked_b, err_b, wrap_b;
    logic [W-1:0] exp_b;
    logic [1:0]   errc_b;

    int checks = 0;
    int errors = 0;

    // Model: 0 = waiting for first sample, 1 = acquiring, 2 = locked
    int m_mode;
    int m_exp;
    int m_run;
    int m_err8;
    int m_err2;
    bit m_errp;
    bit m_wrap;

    count_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in),
        .locked(locked_a), .expected(exp_a), .err_pulse(err_a),
        .wrap_pulse(wrap_a), .err_count(errc_a)
    );

    count_checker #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in),
        .locked(locked_b), .expected(exp_b), .err_pulse(err_b),
        .wrap_pulse(wrap_b), .err_count(errc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance the model, settle 1 time unit after the edge.
    task automatic step(input bit r, input bit e, input int v);
        rst      = r;
        en       = e;
        count_in = W'(v);
        @(posedge clk);
        m_errp = 0;
        m_wrap = 0;
        if (r) begin
            m_mode = 0; m_exp = 0; m_run = 0; m_err8 = 0; m_err2 = 0;
        end else if (e) begin
            if (m_mode == 0) begin
                m_exp = (v + 1) % MODN; m_run = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                m_run = (v == m_exp) ? m_run + 1 : 0;
                m_exp = (v + 1) % MODN;
                if (m_run >= LOCK) begin m_mode = 2; m_run = 0; end
            end else begin
                if (v == m_exp) begin
                    m_wrap = (v == 0);
                    m_exp  = (v + 1) % MODN;
                end
`ifdef COUNT_CHECKER_RST_TOL_EN
                else if (v == 0) begin
                    m_exp = 1;
                end
`endif
                else begin
                    m_errp = 1;
                    m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
                    m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
                    m_exp  = (v + 1) % MODN;
                    m_run  = 0;
                    m_mode = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0);
        step(1, 1, 9);
        checks++;
        if (locked_a !== 1'b0 || exp_a !== 4'd0 || err_a !== 1'b0 || wrap_a !== 1'b0 || errc_a !== 8'd0) begin
            errors++;
            $display("FAIL reset_a: locked=%b exp=%0d err=%b wrap=%b errc=%0d, need all 0",
                     locked_a, exp_a, err_a, wrap_a, errc_a);
        end
        checks++;
        if (locked_b !== 1'b0 || exp_b !== 4'd0 || errc_b !== 2'd0) begin
            errors++;
            $display("FAIL reset_b: locked=%b exp=%0d errc=%0d, need all 0", locked_b, exp_b, errc_b);
        end
    endtask

    task automatic test_lock();
        step(0, 1, 5);
        step(0, 1, 6);
        checks++;
        if (locked_a !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: locked=%b after 2 samples, need 0", locked_a);
        end
        step(0, 1, 7);
        checks++;
        if (locked_a !== 1'b1 || exp_a !== 4'd8 || errc_a !== 8'd0) begin
            errors++;
            $display("FAIL lock_acquire: locked=%b exp=%0d errc=%0d, need 1/8/0", locked_a, exp_a, errc_a);
        end
    endtask

    task automatic test_wrap();
        for (int v = 8; v <= 15; v++) step(0, 1, v);
        step(0, 1, 0);
        checks++;
        if (wrap_a !== 1'b1 || err_a !== 1'b0 || locked_a !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pulse: wrap=%b err=%b locked=%b, need 1/0/1", wrap_a, err_a, locked_a);
        end
        step(0, 1, 1);
        checks++;
        if (wrap_a !== 1'b0 || exp_a !== 4'd2) begin
            errors++;
            $display("FAIL wrap_after: wrap=%b exp=%0d, need 0/2", wrap_a, exp_a);
        end
    endtask

    task automatic test_mismatch();
        for (int v = 2; v <= 8; v++) step(0, 1, v);
        step(0, 1, 3);
        checks++;
        if (err_a !== 1'b1 || errc_a !== 8'd1 || locked_a !== 1'b0 || exp_a !== 4'd4 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL mismatch: err=%b errc=%0d locked=%b exp=%0d wrap=%b, need 1/1/0/4/0",
                     err_a, errc_a, locked_a, exp_a, wrap_a);
        end
        step(0, 1, 4);
        checks++;
        if (err_a !== 1'b0 || locked_a !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_sync: err=%b locked=%b, need 0/0", err_a, locked_a);
        end
        step(0, 1, 5);
        checks++;
        if (locked_a !== 1'b1 || exp_a !== 4'd6 || errc_a !== 8'd1) begin
            errors++;
            $display("FAIL relock: locked=%b exp=%0d errc=%0d, need 1/6/1", locked_a, exp_a, errc_a);
        end
    endtask

    task automatic test_enable_hold();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, int'($urandom_range(0, MODN - 1)));
            checks++;
            if (locked_a !== 1'b1 || exp_a !== 4'd6 || err_a !== 1'b0 || wrap_a !== 1'b0 || errc_a !== 8'd1) begin
                errors++;
                $display("FAIL en_hold[%0d]: locked=%b exp=%0d err=%b wrap=%b errc=%0d, need 1/6/0/0/1",
                         i, locked_a, exp_a, err_a, wrap_a, errc_a);
            end
        end
        step(0, 1, 6);
        checks++;
        if (locked_a !== 1'b1 || err_a !== 1'b0 || exp_a !== 4'd7) begin
            errors++;
            $display("FAIL en_resume: locked=%b err=%b exp=%0d, need 1/0/7", locked_a, err_a, exp_a);
        end
    endtask

    task automatic test_zero_sample();
        for (int v = 7; v <= 9; v++) step(0, 1, v);
        step(0, 1, 0);
`ifdef COUNT_CHECKER_RST_TOL_EN
        checks++;
        if (err_a !== 1'b0 || locked_a !== 1'b1 || exp_a !== 4'd1 || errc_a !== 8'd1 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_tol: err=%b locked=%b exp=%0d errc=%0d wrap=%b, need 0/1/1/1/0",
                     err_a, locked_a, exp_a, errc_a, wrap_a);
        end
`else
        checks++;
        if (err_a !== 1'b1 || locked_a !== 1'b0 || exp_a !== 4'd1 || errc_a !== 8'd2 || wrap_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_err: err=%b locked=%b exp=%0d errc=%0d wrap=%b, need 1/0/1/2/0",
                     err_a, locked_a, exp_a, errc_a, wrap_a);
        end
`endif
        step(0, 1, 1);
        step(0, 1, 2);
        checks++;
        if (locked_a !== 1'b1 || exp_a !== 4'd3) begin
            errors++;
            $display("FAIL zero_relock: locked=%b exp=%0d, need 1/3", locked_a, exp_a);
        end
    endtask

    task automatic test_saturation();
        int bad;
        for (int k = 0; k < 5; k++) begin
            bad = (m_exp + 5) % MODN;
            if (bad == 0) bad = 3;
            step(0, 1, bad);
            checks++;
            if (err_a !== 1'b1 || err_b !== 1'b1 || errc_a !== 8'(m_err8) || errc_b !== 2'(m_err2)) begin
                errors++;
                $display("FAIL sat[%0d]: err=%b/%b errc=%0d/%0d, need 1/1 %0d/%0d",
                         k, err_a, err_b, errc_a, errc_b, m_err8, m_err2);
            end
            step(0, 1, m_exp);
            step(0, 1, m_exp);
        end
        checks++;
        if (errc_b !== 2'd3 || locked_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_final: errc_b=%0d locked_b=%b, need 3/1", errc_b, locked_b);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 4);
        checks++;
        if (locked_a !== 1'b0 || exp_a !== 4'd0 || err_a !== 1'b0 || wrap_a !== 1'b0 || errc_a !== 8'd0 ||
            locked_b !== 1'b0 || errc_b !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: locked=%b/%b exp=%0d errc=%0d/%0d, need all 0",
                     locked_a, locked_b, exp_a, errc_a, errc_b);
        end
        step(0, 1, 12);
        step(0, 1, 13);
        checks++;
        if (locked_a !== 1'b0 || exp_a !== 4'd14) begin
            errors++;
            $display("FAIL reset_idle: locked=%b exp=%0d, need 0/14", locked_a, exp_a);
        end
    endtask

    task automatic test_random();
        int v;
        bit r, e;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) < 80) v = m_exp;
            else if ($urandom_range(0, 9) == 0) v = 0;
            else v = int'($urandom_range(0, MODN - 1));
            step(r, e, v);
            checks++;
            if (locked_a !== (m_mode == 2) || exp_a !== W'(m_exp) || err_a !== m_errp ||
                wrap_a !== m_wrap || errc_a !== 8'(m_err8)) begin
                errors++;
                $display("FAIL rand_a[%0d]: locked=%b exp=%0d err=%b wrap=%b errc=%0d, need %b/%0d/%b/%b/%0d",
                         i, locked_a, exp_a, err_a, wrap_a, errc_a, (m_mode == 2), m_exp, m_errp, m_wrap, m_err8);
            end
            checks++;
            if (locked_b !== (m_mode == 2) || exp_b !== W'(m_exp) || err_b !== m_errp ||
                wrap_b !== m_wrap || errc_b !== 2'(m_err2) || (err_b && wrap_b)) begin
                errors++;
                $display("FAIL rand_b[%0d]: locked=%b exp=%0d err=%b wrap=%b errc=%0d, need %b/%0d/%b/%b/%0d",
                         i, locked_b, exp_b, err_b, wrap_b, errc_b, (m_mode == 2), m_exp, m_errp, m_wrap, m_err2);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; count_in = '0;
        m_mode = 0; m_exp = 0; m_run = 0; m_err8 = 0; m_err2 = 0; m_errp = 0; m_wrap = 0;
        #2;
        test_reset();
        test_lock();
        test_wrap();
        test_mismatch();
        test_enable_hold();
        test_zero_sample();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
